// File: rtl/gpio_uart_pkg.sv
// Shared definitions for the gpio-to-UART trace transmitter.
// Holds the transmit FSM encoding and the UART framing constants.
package gpio_uart_pkg;

  localparam int BITS_PER_BYTE        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-in first-out buffer with a fall-through read port.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == COUNT_FULL);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of a stale entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// Captures every change of the CPU gpio word into a FIFO and sends each
// queued word over an 8N1 UART line, most significant byte first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for a queued word
// ST_START | start bit (low) for one bit period
// ST_DATA  | eight data bits of the current byte, LSB first
// ST_STOP  | stop bit (high); then next byte of the word or back to idle
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gpio,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NUM_BYTES = DATA_WIDTH / BITS_PER_BYTE;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BIT_W     = $clog2(BITS_PER_BYTE);
  localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BITS_PER_BYTE - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q, overflow_d;

  logic                     gpio_changed;
  logic                     baud_tc;
  logic [BITS_PER_BYTE-1:0] cur_byte;

  logic                  fifo_push, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty, fifo_full;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (gpio),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Full is judged on the pre-edge count, so a same-edge pop never frees room.
  always_comb begin
    gpio_changed = (gpio != prev_q);
    prev_d       = gpio;
    fifo_push    = gpio_changed & ~fifo_full;
    overflow_d   = overflow_q | (gpio_changed & fifo_full);
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    fifo_pop   = 1'b0;
    baud_tc    = (baud_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_data;
          byte_idx_d = LAST_BYTE;
          baud_d     = BAUD_LOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tc) begin
          bit_idx_d = '0;
          baud_d    = BAUD_LOAD;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          if (byte_idx_q != '0) begin
            // Next byte is always taken from the top of the shifted word.
            byte_idx_d = byte_idx_q - 1'b1;
            word_d     = word_q << BITS_PER_BYTE;
            baud_d     = BAUD_LOAD;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cur_byte = word_d[DATA_WIDTH-1 -: BITS_PER_BYTE];
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte[bit_idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx: a UART receiver model decodes tx and compares each
// byte against a queue of bytes expected from the gpio changes driven.
module tb_gpio_uart_tx;

  localparam int DW  = 32;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] gpio;
  logic          tx, busy, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q [$];

  gpio_uart_tx #(
    .DATA_WIDTH      (DW),
    .CLKS_PER_BIT    (CPB),
    .FIFO_ADDR_WIDTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .gpio     (gpio),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] w);
    for (int b = DW/8 - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // UART receiver: counts negedges from the first low sample of a frame.
  initial begin : monitor
    int cnt = 0;
    bit active = 0;
    logic [7:0] rx_byte = '0;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
        cnt = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == CPB/2) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (cnt >= CPB/2 + CPB && cnt <= CPB/2 + 8*CPB && ((cnt - CPB/2) % CPB) == 0) begin
          rx_byte[(cnt - CPB/2) / CPB - 1] = tx;
        end else if (cnt == CPB/2 + 9*CPB) begin
          check("stop_bit", 32'(tx), 32'd1);
          rx_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(rx_byte), 32'h100);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", 32'(rx_byte), 32'(exp_b));
          end
        end else if (cnt == 10*CPB - 1) begin
          active = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    int base;
    bit done;

    reset = 1'b1;
    gpio  = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, tx, busy, overflow}, 32'b100);
    reset = 1'b0;

    // Idle: gpio held at 0 must generate nothing.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_state", {29'd0, tx, busy, overflow}, 32'b100);
    end

    // Single word: latency, frame length.
    gpio = 32'hFFFF_FFFF;
    expect_word(32'hFFFF_FFFF);
    @(negedge clk);
    check("capture_tx_high", 32'(tx), 32'd1);
    check("capture_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tx_fall_latency", 32'(tx), 32'd0);
    cnt = 1;
    done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (busy) cnt++;
      else done = 1;
    end
    check("word_busy_cycles", 32'(cnt), 32'd160);
    check("single_word_drained", 32'(exp_q.size()), 32'd0);

    // Byte and bit order.
    gpio = 32'h0000_700A;
    expect_word(32'h0000_700A);
    @(negedge clk);
    wait_idle("order", 1000);
    check("order_drained", 32'(exp_q.size()), 32'd0);

    // No-change filter.
    gpio = 32'h0;
    expect_word(32'h0);
    @(negedge clk);
    wait_idle("zero_word", 1000);
    base = rx_cnt;
    gpio = 32'h7;
    expect_word(32'h7);
    repeat (300) @(negedge clk);
    gpio = 32'h7;
    repeat (300) @(negedge clk);
    check("nochange_bytes", 32'(rx_cnt - base), 32'd4);
    check("nochange_drained", 32'(exp_q.size()), 32'd0);
    check("nochange_ovf", 32'(overflow), 32'd0);

    // Burst into a depth-4 FIFO while the transmitter pops the first word.
    for (int v = 1; v <= 6; v++) begin
      gpio = 32'(v);
      if (v <= 5) expect_word(32'(v));
      @(negedge clk);
      if (v == 5) check("ovf_before_drop", 32'(overflow), 32'd0);
      if (v == 6) check("ovf_on_drop", 32'(overflow), 32'd1);
    end
    wait_idle("burst", 5000);
    check("burst_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame, then the still-present value is sent again.
    base = rx_cnt;
    gpio = 32'h1234_5678;
    expect_word(32'h1234_5678);
    done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (rx_cnt >= base + 1) done = 1;
    end
    if (!done) check("midframe_timeout", 32'd0, 32'd1);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset_state", {29'd0, tx, busy, overflow}, 32'b100);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_word(32'h1234_5678);
    done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (busy) done = 1;
    end
    check("resend_started", 32'(done), 32'd1);
    wait_idle("resend", 1000);
    check("resend_drained", 32'(exp_q.size()), 32'd0);
    check("resend_ovf_clear", 32'(overflow), 32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
